// File: rtl/uart_transmitter.sv
// 8N1 UART transmit path: a small byte FIFO fed by a valid/ready handshake,
// drained by a serialiser that emits start, eight data bits LSB first, and stop.
module uart_transmitter #(
    parameter int CLOCK_PER_BIT = 54,
    parameter int FIFO_ADDR     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] send_data,
    output logic       ready,
    output logic       out,
    output logic       busy,
    output logic       sent
);

    localparam int DEPTH   = 2 ** FIFO_ADDR;
    localparam int TIMER_W = (CLOCK_PER_BIT > 1) ? $clog2(CLOCK_PER_BIT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    state_t               state_r;
    logic [TIMER_W-1:0]   timer_r;
    logic [2:0]           index_r;
    logic [7:0]           shift_r;
    logic                 out_r;
    logic                 sent_r;
    logic [7:0]           mem_r [DEPTH];
    logic [FIFO_ADDR-1:0] wr_ptr_r;
    logic [FIFO_ADDR-1:0] rd_ptr_r;
    logic [FIFO_ADDR:0]   count_r;

    logic                 fifo_empty_s;
    logic                 ready_s;
    logic                 bit_end_s;
    logic                 push_s;
    logic                 pop_s;

    // Handshake, bit-boundary detection and the pop request issued by the serialiser.
    always_comb begin
        fifo_empty_s = (count_r == {(FIFO_ADDR+1){1'b0}});
        ready_s      = (count_r != (FIFO_ADDR+1)'(DEPTH));
        bit_end_s    = (timer_r == TIMER_W'(CLOCK_PER_BIT - 1));
        push_s       = send && ready_s;
        pop_s        = 1'b0;
        case (state_r)
            ST_IDLE: pop_s = !fifo_empty_s;
            ST_STOP: pop_s = bit_end_s && !fifo_empty_s;
            default: pop_s = 1'b0;
        endcase
    end

    // FIFO storage; stale entries are harmless because the pointers are what reset clears.
    always_ff @(posedge clock) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= send_data;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r <= {FIFO_ADDR{1'b0}};
            rd_ptr_r <= {FIFO_ADDR{1'b0}};
            count_r  <= {(FIFO_ADDR+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_ADDR'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_ADDR'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (FIFO_ADDR+1)'(1);
                2'b01:   count_r <= count_r - (FIFO_ADDR+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Serialiser FSM; the stop bit chains straight into the next start bit when bytes are queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            timer_r <= {TIMER_W{1'b0}};
            index_r <= 3'd0;
            shift_r <= 8'h00;
            out_r   <= 1'b1;
            sent_r  <= 1'b0;
        end else begin
            // Registered pulse lands on the final cycle of the stop bit.
            sent_r <= (state_r == ST_STOP) && (timer_r == TIMER_W'(CLOCK_PER_BIT - 2));
            case (state_r)
                ST_IDLE: begin
                    timer_r <= {TIMER_W{1'b0}};
                    if (pop_s) begin
                        shift_r <= mem_r[rd_ptr_r];
                        out_r   <= 1'b0;
                        state_r <= ST_START;
                    end else begin
                        out_r   <= 1'b1;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        timer_r <= {TIMER_W{1'b0}};
                        out_r   <= shift_r[0];
                        index_r <= 3'd0;
                        state_r <= ST_DATA;
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        timer_r <= {TIMER_W{1'b0}};
                        if (index_r == 3'd7) begin
                            out_r   <= 1'b1;
                            state_r <= ST_STOP;
                        end else begin
                            shift_r <= {1'b0, shift_r[7:1]};
                            out_r   <= shift_r[1];
                            index_r <= index_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                ST_STOP: begin
                    if (bit_end_s) begin
                        timer_r <= {TIMER_W{1'b0}};
                        if (pop_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                            out_r   <= 1'b0;
                            state_r <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    timer_r <= {TIMER_W{1'b0}};
                    out_r   <= 1'b1;
                end
            endcase
        end
    end

    assign ready = ready_s;
    assign out   = out_r;
    assign busy  = (state_r != ST_IDLE) || !fifo_empty_s;
    assign sent  = sent_r;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: cycle-exact frame checks, FIFO full/drop,
// mid-frame reset, loopback through a behavioural receiver and pointer wrap.
module tb_uart_transmitter;

    localparam int CPB = 54;

    logic       clock;
    logic       reset;
    logic       send;
    logic [7:0] send_data;
    logic       ready;
    logic       out;
    logic       busy;
    logic       sent;

    int n_compared;
    int n_mismatched;

    uart_transmitter #(.CLOCK_PER_BIT(CPB), .FIFO_ADDR(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .send      (send),
        .send_data (send_data),
        .ready     (ready),
        .out       (out),
        .busy      (busy),
        .sent      (sent)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One byte offered for a single cycle; returns at the negedge after the accepting edge.
    task automatic send_one(input logic [7:0] b);
        send      = 1'b1;
        send_data = b;
        @(negedge clock);
        send      = 1'b0;
        send_data = ~b;
    endtask

    // Checks every cycle of one frame starting at its first start-bit cycle.
    task automatic expect_frame(input logic [7:0] b, input string name);
        logic [9:0] bits;
        int         bad_cnt;
        logic       bad_val;
        int         sent_wrong;
        bits       = {1'b1, b, 1'b0};
        sent_wrong = 0;
        for (int k = 0; k < 10; k++) begin
            bad_cnt = 0;
            bad_val = 1'b0;
            for (int c = 0; c < CPB; c++) begin
                if (out !== bits[k]) begin
                    if (bad_cnt == 0) bad_val = out;
                    bad_cnt++;
                end
                if (sent !== ((k == 9) && (c == CPB - 1))) sent_wrong++;
                @(negedge clock);
            end
            n_compared++;
            if (bad_cnt != 0) begin
                n_mismatched++;
                $display("FAIL %s bit%0d: out=%b on %0d cycles, required %b",
                         name, k, bad_val, bad_cnt, bits[k]);
            end
        end
        n_compared++;
        if (sent_wrong != 0) begin
            n_mismatched++;
            $display("FAIL %s sent: %0d cycles wrong, required single pulse on last stop cycle",
                     name, sent_wrong);
        end
    endtask

    // Behavioural receiver: finds the start bit and samples each bit at its centre.
    task automatic rx_byte(output logic [7:0] b, output logic ok);
        int w;
        b  = 8'h00;
        w  = 0;
        while (out !== 1'b0 && w < 3000) begin
            @(negedge clock);
            w++;
        end
        ok = (out === 1'b0);
        if (ok) begin
            repeat (CPB / 2) @(negedge clock);
            if (out !== 1'b0) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clock);
                b[i] = out;
            end
            repeat (CPB) @(negedge clock);
            if (out !== 1'b1) ok = 1'b0;
            repeat (CPB - CPB / 2) @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        send  = 1'b0;
        send_data = 8'h00;
        repeat (3) @(negedge clock);
        n_compared += 4;
        if (out !== 1'b1)   begin n_mismatched++; $display("FAIL reset_out: got %b need 1", out); end
        if (ready !== 1'b1) begin n_mismatched++; $display("FAIL reset_ready: got %b need 1", ready); end
        if (busy !== 1'b0)  begin n_mismatched++; $display("FAIL reset_busy: got %b need 0", busy); end
        if (sent !== 1'b0)  begin n_mismatched++; $display("FAIL reset_sent: got %b need 0", sent); end
        reset = 1'b0;
        repeat (5) @(negedge clock);
        n_compared += 2;
        if (out !== 1'b1)  begin n_mismatched++; $display("FAIL idle_out: got %b need 1", out); end
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL idle_busy: got %b need 0", busy); end
    endtask

    task automatic test_single_frame();
        send_one(8'h55);
        n_compared += 2;
        if (out !== 1'b1)  begin n_mismatched++; $display("FAIL latency_out_early: got %b need 1", out); end
        if (busy !== 1'b1) begin n_mismatched++; $display("FAIL accept_busy: got %b need 1", busy); end
        @(negedge clock);
        expect_frame(8'h55, "frame55");
        n_compared += 2;
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL busy_after_55: got %b need 0", busy); end
        if (out !== 1'b1)  begin n_mismatched++; $display("FAIL out_after_55: got %b need 1", out); end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_back_to_back();
        send      = 1'b1;
        send_data = 8'hA5;
        @(negedge clock);
        send_data = 8'h3C;
        @(negedge clock);
        send      = 1'b0;
        send_data = 8'h00;
        expect_frame(8'hA5, "b2b_A5");
        expect_frame(8'h3C, "b2b_3C");
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL busy_after_b2b: got %b need 0", busy); end
        repeat (10) @(negedge clock);
    endtask

    task automatic test_fifo_full_drop();
        int high_bad;
        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    send      = 1'b1;
                    send_data = 8'(i);
                    if (i == 6) begin
                        n_compared++;
                        if (ready !== 1'b0) begin n_mismatched++; $display("FAIL full_ready: got %b need 0", ready); end
                    end
                    @(negedge clock);
                end
                send = 1'b0;
                n_compared++;
                if (ready !== 1'b0) begin n_mismatched++; $display("FAIL after_drop_ready: got %b need 0", ready); end
            end
            begin
                @(negedge clock);
                @(negedge clock);
                for (int i = 1; i <= 5; i++) expect_frame(8'(i), "fill");
            end
        join
        n_compared++;
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL busy_after_fill: got %b need 0", busy); end
        high_bad = 0;
        repeat (600) begin
            if (out !== 1'b1) high_bad++;
            @(negedge clock);
        end
        n_compared++;
        if (high_bad != 0) begin n_mismatched++; $display("FAIL dropped_byte_sent: low on %0d cycles need 0", high_bad); end
    endtask

    task automatic test_reset_mid_frame();
        int quiet_bad;
        send      = 1'b1;
        send_data = 8'hF0;
        @(negedge clock);
        send_data = 8'h11;
        @(negedge clock);
        send_data = 8'h22;
        @(negedge clock);
        send      = 1'b0;
        repeat (198) @(negedge clock);
        n_compared += 2;
        if (out !== 1'b0)  begin n_mismatched++; $display("FAIL mid_frame_out: got %b need 0", out); end
        if (busy !== 1'b1) begin n_mismatched++; $display("FAIL mid_frame_busy: got %b need 1", busy); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_compared += 3;
        if (out !== 1'b1)   begin n_mismatched++; $display("FAIL abort_out: got %b need 1", out); end
        if (ready !== 1'b1) begin n_mismatched++; $display("FAIL abort_ready: got %b need 1", ready); end
        if (busy !== 1'b0)  begin n_mismatched++; $display("FAIL abort_busy: got %b need 0", busy); end
        quiet_bad = 0;
        repeat (700) begin
            if (out !== 1'b1 || busy !== 1'b0) quiet_bad++;
            @(negedge clock);
        end
        n_compared++;
        if (quiet_bad != 0) begin n_mismatched++; $display("FAIL frames_after_reset: active on %0d cycles need 0", quiet_bad); end
    endtask

    task automatic test_loopback();
        logic [7:0] vec [4];
        logic [7:0] got;
        logic       ok;
        vec[0] = 8'h00;
        vec[1] = 8'hFF;
        vec[2] = 8'h5A;
        vec[3] = 8'h81;
        for (int i = 0; i < 4; i++) begin
            send_one(vec[i]);
            rx_byte(got, ok);
            n_compared++;
            if (!ok || got !== vec[i]) begin
                n_mismatched++;
                $display("FAIL loopback%0d: got %h (framing ok=%b) need %h", i, got, ok, vec[i]);
            end
            repeat (20) @(negedge clock);
        end
    endtask

    task automatic test_pop_push_wrap();
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    send      = 1'b1;
                    send_data = 8'hC1 + 8'(i);
                    @(negedge clock);
                end
                send = 1'b0;
                n_compared++;
                if (ready !== 1'b0) begin n_mismatched++; $display("FAIL wrap_full_ready: got %b need 0", ready); end
                repeat (536) @(negedge clock);
                send      = 1'b1;
                send_data = 8'h77;
                n_compared++;
                if (ready !== 1'b0) begin n_mismatched++; $display("FAIL pop_edge_ready: got %b need 0", ready); end
                @(negedge clock);
                n_compared++;
                if (ready !== 1'b1) begin n_mismatched++; $display("FAIL after_pop_ready: got %b need 1", ready); end
                send_data = 8'h88;
                @(negedge clock);
                send = 1'b0;
                n_compared++;
                if (ready !== 1'b0) begin n_mismatched++; $display("FAIL refill_ready: got %b need 0", ready); end
            end
            begin
                @(negedge clock);
                @(negedge clock);
                expect_frame(8'hC1, "wrap_C1");
                expect_frame(8'hC2, "wrap_C2");
                expect_frame(8'hC3, "wrap_C3");
                expect_frame(8'hC4, "wrap_C4");
                expect_frame(8'hC5, "wrap_C5");
                expect_frame(8'h88, "wrap_88");
            end
        join
        n_compared += 2;
        if (busy !== 1'b0) begin n_mismatched++; $display("FAIL wrap_busy_end: got %b need 0", busy); end
        if (out !== 1'b1)  begin n_mismatched++; $display("FAIL wrap_out_end: got %b need 1", out); end
    endtask

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        send         = 1'b0;
        send_data    = 8'h00;
        @(negedge clock);
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full_drop();
        test_reset_mid_frame();
        test_loopback();
        test_pop_push_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
